// File: rtl/vid_pkg.sv
// Shared types and constants for the video line prefetcher: FSM states,
// vertical-scale encodings and default widths.
package vid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_FETCH = 2'd2,
    ST_HOLD  = 2'd3
  } pf_state_e;

  localparam logic [1:0] VSCALE_1X  = 2'd0;
  localparam logic [1:0] VSCALE_2X  = 2'd1;
  localparam logic [1:0] VSCALE_4X  = 2'd2;
  localparam logic [1:0] VSCALE_RSV = 2'd3;

  localparam int VID_DATA_W = 32;
  localparam int VID_LINE_W = 12;

  // Right-shift applied to the output line number; the reserved code acts as 4x.
  function automatic logic [1:0] vscale_shift(input logic [1:0] vscale);
    case (vscale)
      VSCALE_1X: return 2'd0;
      VSCALE_2X: return 2'd1;
      default:   return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/video_line_ram_dc.sv
// Simple dual-port, dual-clock line RAM: write on wr_clk_i, registered read on rd_clk_i.
module video_line_ram_dc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
) (
  input  logic              wr_clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_clk_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [1 << ADDR_W];

  always_ff @(posedge wr_clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge rd_clk_i) begin
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/video_line_prefetcher.sv
// VDMA stream to line-bank ring ingest with vertical replication and underrun/length reporting.
// Optional build macro VIDPF_STATS_EN adds saturating underrun/len_err counters.
module video_line_prefetcher
  import vid_pkg::*;
#(
  parameter int  DATA_W    = VID_DATA_W,
  parameter int  MAX_WIDTH = 2048,
  parameter int  NUM_BANKS = 4,
  parameter int  LINE_W    = VID_LINE_W,
  localparam int ADDR_W    = $clog2(MAX_WIDTH),
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              m_axis_vid_aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic              s_tuser,
  input  logic [LINE_W-1:0] line_req,
  input  logic              frame_sync,
  input  logic [1:0]        vscale,
  input  logic              vsync_req,
  input  logic              rd_clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [BANK_W-1:0] rd_bank,
  output logic              underrun,
  output logic              len_err
`ifdef VIDPF_STATS_EN
  ,
  output logic [15:0]       stat_underruns,
  output logic [15:0]       stat_len_errs
`endif
);

  pf_state_e                  state_q, state_d;
  logic [LINE_W-1:0]          wr_line_q, wr_line_d;
  logic [LINE_W-1:0]          src_line_q, src_line_d;
  logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic                       full_q, full_d;
  logic                       lerr_q, lerr_d;
  logic                       vs_flag_q, vs_flag_d;
  logic                       tready_q, src_chg_q, underrun_q, len_err_q;
  logic                       underrun_d, len_err_d;
  logic                       accept, we;
  logic [BANK_W+ADDR_W-1:0]   waddr;
  logic [LINE_W-1:0]          ahead, ahead_next;

  assign accept     = s_tvalid & tready_q;
  assign src_line_d = line_req >> vscale_shift(vscale);
  assign ahead      = wr_line_q - src_line_q;
  assign ahead_next = wr_line_q + LINE_W'(1) - src_line_q;
  // A negative distance (scanout overtook the writer) shows up as the top bit set.
  assign underrun_d = src_chg_q & ((ahead == '0) | ahead[LINE_W-1]);

  always_comb begin
    state_d   = state_q;
    wr_line_d = wr_line_q;
    wr_ptr_d  = wr_ptr_q;
    full_d    = full_q;
    lerr_d    = lerr_q;
    vs_flag_d = vs_flag_q | vsync_req;
    we        = 1'b0;
    waddr     = {wr_line_q[BANK_W-1:0], wr_ptr_q};
    len_err_d = 1'b0;
    case (state_q)
      ST_IDLE: vs_flag_d = 1'b0;
      ST_SYNC: begin
        if (vs_flag_d) begin
          state_d   = ST_IDLE;
          vs_flag_d = 1'b0;
        end else if (frame_sync) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (accept && !s_tuser) begin
          // full_q marks the last bank word as written; later beats of the line are dropped.
          if (!full_q) begin
            we = 1'b1;
            if (wr_ptr_q == ADDR_W'(MAX_WIDTH - 1)) full_d = 1'b1;
            else wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end else if (!lerr_q) begin
            len_err_d = 1'b1;
            lerr_d    = 1'b1;
          end
          if (s_tlast) begin
            wr_line_d = wr_line_q + LINE_W'(1);
            wr_ptr_d  = '0;
            full_d    = 1'b0;
            lerr_d    = 1'b0;
            if (ahead_next < LINE_W'(NUM_BANKS)) begin
              state_d = ST_FETCH;
            end else if (vs_flag_d) begin
              state_d   = ST_IDLE;
              vs_flag_d = 1'b0;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (vs_flag_d) begin
          state_d   = ST_IDLE;
          vs_flag_d = 1'b0;
        end else if (ahead < LINE_W'(NUM_BANKS)) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshakes only happen in IDLE/FETCH, so a tuser beat here always restarts the frame.
    if (accept && s_tuser) begin
      we        = 1'b1;
      waddr     = '0;
      wr_line_d = '0;
      wr_ptr_d  = ADDR_W'(1);
      full_d    = 1'b0;
      lerr_d    = 1'b0;
      state_d   = ST_SYNC;
    end
  end

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      tready_q   <= 1'b0;
      wr_line_q  <= '0;
      wr_ptr_q   <= '0;
      full_q     <= 1'b0;
      lerr_q     <= 1'b0;
      vs_flag_q  <= 1'b0;
      src_line_q <= '0;
      src_chg_q  <= 1'b0;
      underrun_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tready_q   <= (state_d == ST_IDLE) || (state_d == ST_FETCH);
      wr_line_q  <= wr_line_d;
      wr_ptr_q   <= wr_ptr_d;
      full_q     <= full_d;
      lerr_q     <= lerr_d;
      vs_flag_q  <= vs_flag_d;
      src_line_q <= src_line_d;
      src_chg_q  <= (src_line_d != src_line_q);
      underrun_q <= underrun_d;
      len_err_q  <= len_err_d;
    end
  end

  assign s_tready = tready_q;
  assign underrun = underrun_q;
  assign len_err  = len_err_q;
  assign rd_bank  = src_line_q[BANK_W-1:0];

  video_line_ram_dc #(
    .DATA_W (DATA_W),
    .ADDR_W (BANK_W + ADDR_W)
  ) u_ram (
    .wr_clk_i (m_axis_vid_aclk),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (s_tdata),
    .rd_clk_i (rd_clk),
    .raddr_i  ({rd_bank, rd_addr}),
    .rdata_o  (rd_data)
  );

`ifdef VIDPF_STATS_EN
  logic [15:0] stat_und_q, stat_len_q;
  logic        frame_restart;

  assign frame_restart = accept & s_tuser;

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn || frame_restart) begin
      stat_und_q <= '0;
      stat_len_q <= '0;
    end else begin
      if (underrun_d && stat_und_q != 16'hFFFF) stat_und_q <= stat_und_q + 16'd1;
      if (len_err_d && stat_len_q != 16'hFFFF) stat_len_q <= stat_len_q + 16'd1;
    end
  end

  assign stat_underruns = stat_und_q;
  assign stat_len_errs  = stat_len_q;
`endif

endmodule

// File: tb/tb_video_line_prefetcher.sv
// Bench for video_line_prefetcher: randomized beats/gaps checked against a line/word memory model.
module tb_video_line_prefetcher;

  localparam int DATA_W    = 32;
  localparam int MAX_WIDTH = 16;
  localparam int NUM_BANKS = 4;
  localparam int LINE_W    = 12;
  localparam int ADDR_W    = 4;
  localparam int BANK_W    = 2;

  logic              clk = 1'b0;
  logic              rd_clk = 1'b0;
  logic              aresetn = 1'b0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic              s_tlast = 1'b0;
  logic              s_tuser = 1'b0;
  logic [LINE_W-1:0] line_req = '0;
  logic              frame_sync = 1'b0;
  logic [1:0]        vscale = 2'd0;
  logic              vsync_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic [BANK_W-1:0] rd_bank;
  logic              underrun;
  logic              len_err;

  always #5 clk = ~clk;
  always #4 rd_clk = ~rd_clk;

  video_line_prefetcher #(
    .DATA_W(DATA_W), .MAX_WIDTH(MAX_WIDTH), .NUM_BANKS(NUM_BANKS), .LINE_W(LINE_W)
  ) dut (
    .m_axis_vid_aclk(clk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .line_req(line_req), .frame_sync(frame_sync), .vscale(vscale), .vsync_req(vsync_req),
    .rd_clk(rd_clk), .rd_addr(rd_addr), .rd_data(rd_data), .rd_bank(rd_bank),
    .underrun(underrun), .len_err(len_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int und_cnt = 0;
  int lerr_cnt = 0;
  logic [7:0]        tag;
  logic [DATA_W-1:0] model_mem [NUM_BANKS*MAX_WIDTH];

  always @(negedge clk) begin
    if (underrun === 1'b1) und_cnt++;
    if (len_err === 1'b1) lerr_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] beat(input int line, input int word);
    return {tag, 12'(line), 12'(word)};
  endfunction

  function automatic int exp_src(input int lr, input int vs);
    return lr >> ((vs >= 2) ? 2 : vs);
  endfunction

  function automatic int exp_underrun(input int wl, input int src);
    int a;
    a = ((wl - src) % 4096 + 4096) % 4096;
    return (a == 0 || a >= 2048) ? 1 : 0;
  endfunction

  task automatic model_store(input int line, input int word, input logic [DATA_W-1:0] d);
    if (word < MAX_WIDTH) model_mem[(line % NUM_BANKS)*MAX_WIDTH + word] = d;
  endtask

  // ---------------- drivers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input bit last, input bit user,
                      input int budget, output bit ok);
    s_tvalid = 1'b0;
    cyc($urandom_range(0, 1));
    s_tdata = d; s_tlast = last; s_tuser = user; s_tvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (s_tready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic push_line(input int line, input int w0, input int nw, input bit with_last,
                           output bit ok);
    bit b;
    ok = 1'b1;
    for (int w = w0; w < nw; w++) begin
      push(beat(line, w), with_last && (w == nw - 1), 1'b0, (w == w0) ? 30 : 10, b);
      if (!b) begin ok = 1'b0; return; end
      model_store(line, w, beat(line, w));
    end
  endtask

  task automatic start_frame(output bit ok);
    tag = 8'($urandom);
    push(beat(0, 0), 1'b0, 1'b1, 20, ok);
    if (ok) model_store(0, 0, beat(0, 0));
  endtask

  task automatic pulse_frame_sync();
    cyc(2);
    frame_sync = 1'b1; cyc(1); frame_sync = 1'b0;
  endtask

  task automatic read_word(input int addr, output logic [DATA_W-1:0] d);
    rd_addr = ADDR_W'(addr);
    repeat (3) @(posedge rd_clk);
    #1;
    d = rd_data;
  endtask

  task automatic quiet_reset();
    line_req = '0; vscale = 2'd0; s_tvalid = 1'b0; frame_sync = 1'b0; vsync_req = 1'b0;
    aresetn = 1'b0; cyc(2); aresetn = 1'b1; cyc(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0; cyc(2);
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL reset_len_err: got %b want 0", len_err); end
    aresetn = 1'b1; cyc(1);
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL reset_release_tready: got %b want 1", s_tready); end
  endtask

  task automatic test_prefetch();
    bit ok, exp_ok;
    int lines, src, base;
    logic [DATA_W-1:0] d;
    int a;
    base = und_cnt;
    start_frame(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL pf_tuser_accept: got 0 want 1"); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL pf_sync_tready: got %b want 0", s_tready); end
    cyc(3);
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL pf_sync_hold: got %b want 0", s_tready); end
    pulse_frame_sync();
    push_line(0, 1, 8, 1'b1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL pf_line0: got 0 want 1"); end
    lines = 1; src = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin line_req = 12'd1; src = 1; cyc(2); end
      exp_ok = (lines - src) < NUM_BANKS;
      push_line(lines, 0, 8, 1'b1, ok);
      n_cmp++;
      if (ok !== exp_ok) begin n_err++; $display("FAIL pf_line_accept[%0d]: got %0d want %0d", lines, ok, exp_ok); end
      if (ok) begin
        lines++;
        if ((lines - src) >= NUM_BANKS) begin
          n_cmp++;
          if (s_tready !== 1'b0) begin n_err++; $display("FAIL pf_ready_after_tlast[%0d]: got %b want 0", lines, s_tready); end
        end
      end
    end
    cyc(4);
    n_cmp++; if (rd_bank !== 2'(1)) begin n_err++; $display("FAIL pf_rd_bank1: got %0d want 1", rd_bank); end
    for (int i = 0; i < 3; i++) begin
      a = $urandom_range(0, 7);
      read_word(a, d);
      n_cmp++;
      if (d !== model_mem[MAX_WIDTH + a]) begin n_err++; $display("FAIL pf_data_bank1[%0d]: got %h want %h", a, d, model_mem[MAX_WIDTH + a]); end
    end
    line_req = 12'd4; cyc(4);
    n_cmp++; if (rd_bank !== 2'(0)) begin n_err++; $display("FAIL pf_rd_bank0: got %0d want 0", rd_bank); end
    a = $urandom_range(0, 7);
    read_word(a, d);
    n_cmp++; if (d !== beat(4, a)) begin n_err++; $display("FAIL pf_data_line4[%0d]: got %h want %h", a, d, beat(4, a)); end
    n_cmp++; if (und_cnt - base != 0) begin n_err++; $display("FAIL pf_no_underrun: got %0d want 0", und_cnt - base); end
  endtask

  task automatic test_vscale();
    bit ok;
    int base, s, a;
    logic [DATA_W-1:0] d;
    int lrs[2] = '{8, 13};
    int vss[2] = '{2, 3};
    quiet_reset();
    vscale = 2'd1;
    base = und_cnt;
    start_frame(ok);
    pulse_frame_sync();
    push_line(0, 1, 8, 1'b1, ok);
    for (int l = 1; l < 4; l++) push_line(l, 0, 8, 1'b1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL vs_fill: got 0 want 1"); end
    for (int lr = 0; lr < 8; lr++) begin
      line_req = 12'(lr); cyc(5);
      s = exp_src(lr, 1);
      n_cmp++;
      if (rd_bank !== 2'(s % NUM_BANKS)) begin n_err++; $display("FAIL vs_rd_bank[%0d]: got %0d want %0d", lr, rd_bank, s % NUM_BANKS); end
      a = $urandom_range(0, 7);
      read_word(a, d);
      n_cmp++;
      if (d !== beat(s, a)) begin n_err++; $display("FAIL vs_data[%0d]: got %h want %h", lr, d, beat(s, a)); end
    end
    for (int i = 0; i < 2; i++) begin
      vscale = 2'(vss[i]); line_req = 12'(lrs[i]); cyc(5);
      s = exp_src(lrs[i], vss[i]);
      n_cmp++;
      if (rd_bank !== 2'(s % NUM_BANKS)) begin n_err++; $display("FAIL vs_wide_bank[%0d]: got %0d want %0d", i, rd_bank, s % NUM_BANKS); end
    end
    n_cmp++; if (und_cnt - base != 0) begin n_err++; $display("FAIL vs_no_underrun: got %0d want 0", und_cnt - base); end
  endtask

  task automatic test_underrun();
    bit ok;
    int base, exp;
    int seq[4] = '{2, 1, 3, 1};
    quiet_reset();
    start_frame(ok);
    pulse_frame_sync();
    push_line(0, 1, 8, 1'b1, ok);
    push_line(1, 0, 8, 1'b1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ur_fill: got 0 want 1"); end
    for (int i = 0; i < 4; i++) begin
      base = und_cnt;
      line_req = 12'(seq[i]); cyc(6);
      exp = exp_underrun(2, seq[i]);
      n_cmp++;
      if (und_cnt - base != exp) begin n_err++; $display("FAIL ur_pulses[%0d]: got %0d want %0d", seq[i], und_cnt - base, exp); end
    end
  endtask

  task automatic test_len_err();
    bit ok;
    int base;
    logic [DATA_W-1:0] d;
    quiet_reset();
    start_frame(ok);
    pulse_frame_sync();
    base = lerr_cnt;
    push_line(0, 1, MAX_WIDTH + 5, 1'b1, ok);
    cyc(2);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL le_long_line: got 0 want 1"); end
    n_cmp++; if (lerr_cnt - base != 1) begin n_err++; $display("FAIL le_pulses: got %0d want 1", lerr_cnt - base); end
    push_line(1, 0, 8, 1'b1, ok);
    cyc(2);
    n_cmp++; if (lerr_cnt - base != 1) begin n_err++; $display("FAIL le_next_line_clean: got %0d want 1", lerr_cnt - base); end
    for (int a = 0; a < MAX_WIDTH; a++) begin
      read_word(a, d);
      n_cmp++;
      if (d !== model_mem[a]) begin n_err++; $display("FAIL le_bank0[%0d]: got %h want %h", a, d, model_mem[a]); end
    end
    line_req = 12'd1; cyc(4);
    read_word(0, d);
    n_cmp++; if (d !== beat(1, 0)) begin n_err++; $display("FAIL le_next_addr0: got %h want %h", d, beat(1, 0)); end
  endtask

  task automatic test_restart_vsync_reset();
    bit ok;
    logic [DATA_W-1:0] d;
    quiet_reset();
    start_frame(ok);
    pulse_frame_sync();
    push_line(0, 1, 4, 1'b0, ok);
    tag = 8'($urandom);
    push(beat(0, 0), 1'b0, 1'b1, 10, ok);
    if (ok) model_store(0, 0, beat(0, 0));
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rs_midline_tuser: got 0 want 1"); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rs_sync_tready: got %b want 0", s_tready); end
    pulse_frame_sync();
    push_line(0, 1, 8, 1'b1, ok);
    for (int l = 1; l < 4; l++) push_line(l, 0, 8, 1'b1, ok);
    read_word(1, d);
    n_cmp++; if (d !== beat(0, 1)) begin n_err++; $display("FAIL rs_addr1: got %h want %h", d, beat(0, 1)); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rs_hold_tready: got %b want 0", s_tready); end
    vsync_req = 1'b1; cyc(1); vsync_req = 1'b0; cyc(2);
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL rs_vsync_idle: got %b want 1", s_tready); end
    push(32'hDEAD_BEEF, 1'b0, 1'b0, 10, ok);
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL rs_idle_discard_ready: got %b want 1", s_tready); end
    read_word(0, d);
    n_cmp++; if (d !== model_mem[0]) begin n_err++; $display("FAIL rs_idle_discard_data: got %h want %h", d, model_mem[0]); end
    start_frame(ok);
    pulse_frame_sync();
    push_line(0, 1, 3, 1'b0, ok);
    aresetn = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hBAD0_BAD0;
    cyc(1);
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rs_reset_tready: got %b want 0", s_tready); end
    n_cmp++; if (underrun !== 1'b0 || len_err !== 1'b0) begin n_err++; $display("FAIL rs_reset_pulses: got %b%b want 00", underrun, len_err); end
    s_tvalid = 1'b0; aresetn = 1'b1; cyc(1);
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL rs_reset_release: got %b want 1", s_tready); end
    push(32'h1234_5678, 1'b0, 1'b0, 10, ok);
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL rs_reset_idle: got %b want 1", s_tready); end
    read_word(1, d);
    n_cmp++; if (d !== model_mem[1]) begin n_err++; $display("FAIL rs_ram_kept: got %h want %h", d, model_mem[1]); end
    read_word(0, d);
    n_cmp++; if (d !== model_mem[0]) begin n_err++; $display("FAIL rs_reset_discard: got %h want %h", d, model_mem[0]); end
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_vscale();
    test_underrun();
    test_len_err();
    test_restart_vsync_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
